// File: rtl/netwalk_rr_arbiter.sv
// Round-robin arbiter sharing one netwalk resource among N = 2**IDX_WIDTH requesters.
// The grant is registered and held until done, request drop, or the hold watchdog fires.
module netwalk_rr_arbiter #(
  parameter int unsigned IDX_WIDTH      = 6,
  parameter int unsigned HOLD_CNT_WIDTH = 8,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [(1<<IDX_WIDTH)-1:0]  req,
  input  logic                       done,
  output logic [(1<<IDX_WIDTH)-1:0]  grant,
  output logic [IDX_WIDTH-1:0]       grant_idx,
  output logic                       grant_valid,
  output logic                       timeout
);

  localparam int unsigned N = 1 << IDX_WIDTH;
  localparam logic [HOLD_CNT_WIDTH-1:0] HoldLast = HOLD_CNT_WIDTH'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                    state_q, state_d;
  logic [N-1:0]              grant_q, grant_d;
  logic [IDX_WIDTH-1:0]      grant_idx_q, grant_idx_d;
  logic                      timeout_q, timeout_d;
  logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;

  logic                 found;
  logic [IDX_WIDTH-1:0] win;
  logic [IDX_WIDTH-1:0] cand;
  logic                 rel_owner;
  logic                 rel_wdog;

  // Search upward from ptr; the IDX_WIDTH-bit add wraps N-1 back to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_q + IDX_WIDTH'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Owner-side release (done or request drop) outranks the watchdog.
  assign rel_owner = done || !req[grant_idx_q];
  assign rel_wdog  = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast) && !rel_owner;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d      = StHold;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          grant_idx_d  = win;
          hold_cnt_d   = '0;
          ptr_d        = win + IDX_WIDTH'(1);
        end
      end
      StHold: begin
        if (rel_owner || rel_wdog) begin
          state_d     = StIdle;
          grant_d     = '0;
          grant_idx_d = '0;
          timeout_d   = rel_wdog;
          hold_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = (state_q == StHold);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_netwalk_rr_arbiter.sv
// Directed bench for netwalk_rr_arbiter with default parameters (64 requesters, MAX_HOLD=16).
module tb_netwalk_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] req;
  logic        done;
  logic [63:0] grant;
  logic [5:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks;
  int errors;

  netwalk_rr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [63:0] eg, input logic [5:0] ei,
                           input logic ev, input logic et);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".idx"}, {58'b0, grant_idx}, {58'b0, ei});
    check({tag, ".valid"}, {63'b0, grant_valid}, {63'b0, ev});
    check({tag, ".timeout"}, {63'b0, timeout}, {63'b0, et});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = '1;
    done   = 1'b0;

    // 1: reset held two cycles with all requests high
    step();
    step();
    check_out("t1_reset", 64'h0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check_out("t1_first", 64'h1, 6'd0, 1'b1, 1'b0);

    // 2: clean reset, then requesters 5 and 9
    reset = 1'b0;
    req   = '0;
    step();
    reset = 1'b1;
    req   = (64'h1 << 5) | (64'h1 << 9);
    step();
    check_out("t2_grant5", 64'h20, 6'd5, 1'b1, 1'b0);
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check_out("t2_gap", 64'h0, 6'd0, 1'b0, 1'b0);
    step();
    check_out("t2_grant9", 64'h200, 6'd9, 1'b1, 1'b0);
    req = '0;
    step();
    check_out("t2_rel9", 64'h0, 6'd0, 1'b0, 1'b0);

    // 3: grant 63, then pointer wraps to 0
    req = 64'h1 << 63;
    step();
    check_out("t3_grant63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0);
    req = (64'h1 << 62) | 64'h1;
    step();
    check_out("t3_rel63", 64'h0, 6'd0, 1'b0, 1'b0);
    step();
    check_out("t3_wrap0", 64'h1, 6'd0, 1'b1, 1'b0);
    req = '0;
    step();
    check_out("t3_rel0", 64'h0, 6'd0, 1'b0, 1'b0);

    // 4: watchdog, grant held exactly 16 cycles
    req = 64'h8;
    step();
    for (int k = 0; k < 16; k++) begin
      check("t4_held_valid", {63'b0, grant_valid}, 64'h1);
      check("t4_held_to", {63'b0, timeout}, 64'h0);
      step();
    end
    check_out("t4_timeout", 64'h0, 6'd0, 1'b0, 1'b1);
    step();
    check_out("t4_regrant", 64'h8, 6'd3, 1'b1, 1'b0);

    // 5a: done on the 16th held cycle beats the watchdog
    for (int k = 0; k < 15; k++) step();
    check("t5_cycle16_valid", {63'b0, grant_valid}, 64'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    check_out("t5_done_last", 64'h0, 6'd0, 1'b0, 1'b0);
    step();
    check_out("t5_regrant", 64'h8, 6'd3, 1'b1, 1'b0);
    // 5b: done and request drop together form a single release
    done = 1'b1;
    req  = '0;
    step();
    done = 1'b0;
    check_out("t5_dual_rel", 64'h0, 6'd0, 1'b0, 1'b0);
    step();
    check_out("t5_stay_idle", 64'h0, 6'd0, 1'b0, 1'b0);

    // 6: reset mid-hold
    req = 64'h1 << 40;
    step();
    check_out("t6_grant40", 64'h1 << 40, 6'd40, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    step();
    check_out("t6_reset", 64'h0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    req   = (64'h1 << 40) | 64'h4;
    step();
    check_out("t6_grant2", 64'h4, 6'd2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/netwalk_rr_arbiter.md
Name: netwalk_rr_arbiter

Overview:
- Round-robin arbiter that shares one netwalk resource, such as a walk engine or table port, among up to 64 requesters.
- Takes a flat request vector and issues a registered one-hot grant plus its binary index. The index uses the same one-hot to index mapping as netwalk_encoder: bit i maps to i.
- Holds each grant until the owner signals done, drops its request, or a hold watchdog expires.
- Sits between requester ports and the shared resource; grant_idx drives the resource's select mux.

Parameters:
- IDX_WIDTH, 6, width of grant_idx. N = 1<<IDX_WIDTH requesters (64 by default).
- HOLD_CNT_WIDTH, 8, width of the hold watchdog counter.
- MAX_HOLD, 16, maximum number of consecutive cycles a grant may be held. 0 disables the watchdog. Must be less than 2^HOLD_CNT_WIDTH.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Synchronous, active-low: reset=0 sampled at a rising clk edge clears all state.
- req  input  N  Request vector; bit i is requester i. Level-sensitive.
- done  input  1  One-cycle pulse from the current owner or the resource ending the transaction.
- grant  output  N  Registered one-hot grant; all zero when no grant is held.
- grant_idx  output  IDX_WIDTH  Binary index of the set grant bit; 0 when grant_valid=0.
- grant_valid  output  1  High while in HOLD.
- timeout  output  1  One-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; grant, grant_idx, grant_valid, timeout all 0.
  - ptr=0, hold_cnt=0.
  - Reset overrides everything, including mid-HOLD: the next cycle shows grant=0.
- States:
  - IDLE: no grant held.
  - HOLD: grant registered and stable.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w: the first set req bit searching upward from ptr and wrapping N-1 to 0.
  - At the next edge: grant=1<<w, grant_idx=w, grant_valid=1, hold_cnt=0, ptr=(w+1) mod N, state=HOLD.
  - Latency: req sampled in IDLE at edge t gives grant visible after edge t.
- HOLD, release conditions, evaluated every cycle:
  - (a) done=1;
  - (b) req[grant_idx]=0;
  - (c) MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and neither (a) nor (b) holds.
- HOLD, on release at edge t:
  - grant=0, grant_idx=0, grant_valid=0, state=IDLE.
  - timeout=1 for exactly one cycle, only for cause (c).
- HOLD, with no release: hold_cnt increments; grant is unchanged.
- Arbitration gap: after a release there is always at least one cycle with grant_valid=0 (bus turnaround). Re-arbitration happens from IDLE on the following edge.
- Simultaneous release causes:
  - (a) and (b) together count as one release.
  - If (a) or (b) occurs in the watchdog's final cycle, it takes precedence and timeout stays 0.
- Ignored inputs:
  - done is ignored in IDLE.
  - Changes to non-owner req bits during HOLD are ignored until the next IDLE.
- A grant never lasts more than MAX_HOLD cycles.
- Fairness: the owner has the lowest priority in the next arbitration. A requester held high is granted within N arbitration rounds.
- Pointer wrap: granting index N-1 sets ptr=0.
- Outputs are pure registers; there is no combinational path from inputs to outputs.
- Invariant: grant is one-hot or zero, and grant_idx always equals the encoder mapping of grant.

Test Plan:
1. Reset with reset=0 for 2 cycles while req=64'hFFFF_FFFF_FFFF_FFFF -> all outputs 0. Release reset -> one edge later grant=64'h1, grant_idx=0, grant_valid=1.
2. After reset, req bits 5 and 9 set. Pulse done 3 cycles after the grant -> idx 5 granted first. One cycle follows with grant_valid=0, then grant_idx=9, grant=64'h200.
3. Wrap: after idx 63 is granted and released, req bits 0 and 62 set -> grant_idx=0 (ptr wrapped to 0).
4. Watchdog, MAX_HOLD=16: req[3] held, done never pulsed -> grant_valid high exactly 16 cycles. timeout=1 in the cycle grant drops. With only req[3] still set, idx 3 is re-granted after the 1-cycle gap.
5. On the 16th held cycle, done=1 -> release with timeout=0. In a separate run, req[grant_idx] dropping together with done -> a single release.
6. Reset asserted mid-HOLD at idx 40 -> next cycle grant=0, grant_valid=0. After reset, req bits 40 and 2 set -> idx 2 granted (ptr back at 0).
